serial_add_sub: RTL and testbench

//   Parametrised bit-serial adder/subtractor, LSB first, one bit per clock.

---
 rtl/serial_add_sub.sv | 153 +++++++++++++++
 tb/tb_serial_add_sub.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial adder/subtractor. Operands are processed LSB first, one bit per
//   clock, using a single full-adder cell and a carry flip-flop. An operation
//   takes WIDTH RUN cycles followed by a one-cycle DONE pulse.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin an operation (accepted in IDLE or DONE)
//   sub        : 0 = a+b, 1 = a-b; sampled with start
//   a, b       : WIDTH-bit operands; sampled with start
//   busy       : high while the bit-serial loop runs (WIDTH cycles)
//   done       : one-cycle pulse; result/carry_out/overflow are valid
//   result     : (a +/- b) mod 2^WIDTH, held until the next completion
//   carry_out  : carry out of the MSB; for subtraction 1 means a >= b
//   overflow   : two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Full-adder cell
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // Counter increment that sticks at WIDTH
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
    endfunction

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
    logic               carry_q,     carry_d;
    logic [WIDTH-1:0]   acc_q,       acc_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q,  overflow_d;

    logic               s_bit;
    logic               c_next;
    logic [WIDTH-1:0]   acc_shift;

    always_comb begin
        // Full-adder over the current LSBs; only consumed in RUN
        s_bit     = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
        c_next    = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);
        acc_shift = {s_bit, acc_q[WIDTH-1:1]};

        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b and seed carry with 1
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d   = acc_shift;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = c_next;
                cnt_d   = sat_inc(cnt_q);
                if (cnt_q == CNT_LAST) begin
                    // carry_q is the carry into the MSB on this last bit
                    result_d    = acc_shift;
                    carry_out_d = c_next;
                    overflow_d  = carry_q ^ c_next;
                    state_d     = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
//   Scoreboard bench for serial_add_sub. Two instances: WIDTH=8 driven with
//   directed vectors, WIDTH=2 driven over all operand/mode combinations.
//   Drivers push expected responses into queues; monitors pop on done.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

    typedef struct {
        logic [7:0] res;
        logic       co;
        logic       ov;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // WIDTH=8 instance
    logic       rst_n, s8_start, s8_sub, s8_busy, s8_done, s8_co, s8_ov;
    logic [7:0] s8_a, s8_b, s8_result;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .sub(s8_sub),
        .a(s8_a), .b(s8_b), .busy(s8_busy), .done(s8_done),
        .result(s8_result), .carry_out(s8_co), .overflow(s8_ov)
    );

    // WIDTH=2 instance
    logic       rst2_n, s2_start, s2_sub, s2_busy, s2_done, s2_co, s2_ov;
    logic [1:0] s2_a, s2_b, s2_result;

    serial_add_sub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .start(s2_start), .sub(s2_sub),
        .a(s2_a), .b(s2_b), .busy(s2_busy), .done(s2_done),
        .result(s2_result), .carry_out(s2_co), .overflow(s2_ov)
    );

    exp_t q8[$];
    exp_t q2[$];
    exp_t e8, e2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- monitors ----------------
    initial begin : mon8
        int  run;
        logic prev;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run  = 0;
                prev = 1'b0;
            end else begin
                if (s8_busy) run++;
                else if (run != 0) begin
                    chk("busy8_width", run, 8);
                    run = 0;
                end
                if (s8_done) begin
                    if (prev) chk("done8_one_cycle", 1, {31'd0, prev ^ 1'b1});
                    if (q8.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL done8_unexpected actual=1 required=0");
                    end else begin
                        e8 = q8.pop_front();
                        chk("res8", s8_result, e8.res);
                        chk("co8", s8_co, e8.co);
                        chk("ov8", s8_ov, e8.ov);
                        chk("lat8", cyc - e8.acc, 8);
                    end
                end
                prev = s8_done;
            end
        end
    end

    initial begin : mon2
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst2_n) run = 0;
            else begin
                if (s2_busy) run++;
                else if (run != 0) begin
                    chk("busy2_width", run, 2);
                    run = 0;
                end
                if (s2_done) begin
                    if (q2.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL done2_unexpected actual=1 required=0");
                    end else begin
                        e2 = q2.pop_front();
                        chk("res2", s2_result, e2.res);
                        chk("co2", s2_co, e2.co);
                        chk("ov2", s2_ov, e2.ov);
                        chk("lat2", cyc - e2.acc, 2);
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_done8();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s8_done) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout8 actual=no_done required=done");
    endtask

    task automatic wait_done2();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s2_done) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout2 actual=no_done required=done");
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input logic [7:0] er, input logic eco, input logic eov);
        @(negedge clk);
        s8_a = ia; s8_b = ib; s8_sub = isub; s8_start = 1'b1;
        @(posedge clk);
        #1;
        q8.push_back('{res: er, co: eco, ov: eov, acc: cyc});
        s8_start = 1'b0;
        wait_done8();
    endtask

    task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic isub);
        logic [1:0] bb;
        logic [2:0] t;
        bb = isub ? ~ib : ib;
        t  = {1'b0, ia} + {1'b0, bb} + {2'b00, isub};
        @(negedge clk);
        s2_a = ia; s2_b = ib; s2_sub = isub; s2_start = 1'b1;
        @(posedge clk);
        #1;
        q2.push_back('{res: {6'd0, t[1:0]}, co: t[2],
                       ov: (ia[1] == bb[1]) && (t[1] != ia[1]), acc: cyc});
        s2_start = 1'b0;
        wait_done2();
    endtask

    task automatic run8();
        // plain directed vectors
        op8(8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8(8'h20, 8'h20, 1'b1, 8'h00, 1'b1, 1'b0);

        // start pulsed during RUN with different operands is ignored
        @(negedge clk);
        s8_a = 8'h3C; s8_b = 8'h55; s8_sub = 1'b0; s8_start = 1'b1;
        @(posedge clk);
        #1;
        q8.push_back('{res: 8'h91, co: 1'b0, ov: 1'b1, acc: cyc});
        s8_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        s8_a = 8'h11; s8_b = 8'h22; s8_sub = 1'b1; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        wait_done8();

        // start held through RUN into DONE: two operations back to back
        @(negedge clk);
        s8_a = 8'hFF; s8_b = 8'h01; s8_sub = 1'b0; s8_start = 1'b1;
        @(posedge clk);
        #1;
        q8.push_back('{res: 8'h00, co: 1'b1, ov: 1'b0, acc: cyc});
        s8_a = 8'h10; s8_b = 8'h20; s8_sub = 1'b1;
        for (int i = 0; i < 30 && !s8_done; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        q8.push_back('{res: 8'hF0, co: 1'b0, ov: 1'b0, acc: cyc});
        s8_start = 1'b0;
        wait_done8();

        // leave nonzero outputs, then reset in the middle of an operation
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);
        s8_a = 8'h12; s8_b = 8'h34; s8_sub = 1'b0; s8_start = 1'b1;
        @(posedge clk);
        #1;
        s8_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", s8_result, 8'h00);
        chk("midrst_co", s8_co, 0);
        chk("midrst_ov", s8_ov, 0);
        chk("midrst_busy", s8_busy, 0);
        chk("midrst_done", s8_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("postrst_busy", s8_busy, 0);
        chk("postrst_result", s8_result, 8'h00);

        // normal operation after reset
        op8(8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1);
    endtask

    task automatic run2();
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++)
                    op2(2'(x), 2'(y), 1'(s));
    endtask

    initial begin : main
        rst_n = 1'b0; rst2_n = 1'b0;
        s8_start = 1'b0; s8_sub = 1'b0; s8_a = '0; s8_b = '0;
        s2_start = 1'b0; s2_sub = 1'b0; s2_a = '0; s2_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", s8_result, 8'h00);
        chk("rst_co", s8_co, 0);
        chk("rst_ov", s8_ov, 0);
        chk("rst_busy", s8_busy, 0);
        chk("rst_done", s8_done, 0);
        rst_n = 1'b1; rst2_n = 1'b1;
        fork
            run8();
            run2();
        join
        repeat (5) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
